// File: rtl/sram_mem_ctrl.sv
// MEM-stage back end for a 16-bit asynchronous SRAM: each 32-bit access is split into two halfword phases.
// Optional one-entry read cache enabled by defining SRAM_MEM_CTRL_READ_CACHE_EN.
module sram_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_rm,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic        freeze,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StWrLo, StWrHi, StRdLo, StRdHi, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [16:0]     idx_q;
    logic [15:0]     wdata_hi_q;
    logic [31:0]     rd_data_q;
    logic [17:0]     sram_addr_q;
    logic [15:0]     sram_dq_out_q;
    logic            sram_dq_oe_q;
    logic            sram_we_n_q;
    logic [16:0]     req_idx;
    logic            phase_last;

    assign req_idx    = 17'((alu_res - 32'(ADDR_BASE)) >> 2);
    assign phase_last = (cnt_q == CntLast);

`ifdef SRAM_MEM_CTRL_READ_CACHE_EN
    logic        cache_valid_q;
    logic [16:0] cache_idx_q;
    logic [31:0] cache_data_q;
    logic        cache_hit;

    assign cache_hit = cache_valid_q && (cache_idx_q == req_idx);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            idx_q         <= '0;
            wdata_hi_q    <= '0;
            rd_data_q     <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
`ifdef SRAM_MEM_CTRL_READ_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_idx_q   <= '0;
            cache_data_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    // Address and store data are latched here; later input changes are ignored.
                    if (mem_w_en) begin
                        state_q       <= StWrLo;
                        idx_q         <= req_idx;
                        wdata_hi_q    <= val_rm[31:16];
                        sram_addr_q   <= {req_idx, 1'b0};
                        sram_dq_out_q <= val_rm[15:0];
                        sram_dq_oe_q  <= 1'b1;
                        sram_we_n_q   <= 1'b0;
`ifdef SRAM_MEM_CTRL_READ_CACHE_EN
                        if (cache_hit) cache_data_q <= val_rm;
`endif
                    end else if (mem_r_en) begin
`ifdef SRAM_MEM_CTRL_READ_CACHE_EN
                        if (cache_hit) begin
                            state_q   <= StDone;
                            rd_data_q <= cache_data_q;
                        end else begin
                            state_q     <= StRdLo;
                            idx_q       <= req_idx;
                            sram_addr_q <= {req_idx, 1'b0};
                        end
`else
                        state_q     <= StRdLo;
                        idx_q       <= req_idx;
                        sram_addr_q <= {req_idx, 1'b0};
`endif
                    end
                end
                StWrLo: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (phase_last) begin
                        cnt_q         <= '0;
                        state_q       <= StWrHi;
                        sram_addr_q   <= {idx_q, 1'b1};
                        sram_dq_out_q <= wdata_hi_q;
                    end
                end
                StWrHi: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (phase_last) begin
                        cnt_q        <= '0;
                        state_q      <= StDone;
                        sram_dq_oe_q <= 1'b0;
                        sram_we_n_q  <= 1'b1;
                    end
                end
                StRdLo: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (phase_last) begin
                        cnt_q           <= '0;
                        state_q         <= StRdHi;
                        rd_data_q[15:0] <= sram_dq_in;
                        sram_addr_q     <= {idx_q, 1'b1};
                    end
                end
                StRdHi: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (phase_last) begin
                        cnt_q            <= '0;
                        state_q          <= StDone;
                        rd_data_q[31:16] <= sram_dq_in;
`ifdef SRAM_MEM_CTRL_READ_CACHE_EN
                        cache_valid_q <= 1'b1;
                        cache_idx_q   <= idx_q;
                        cache_data_q  <= {sram_dq_in, rd_data_q[15:0]};
`endif
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Ready drops combinationally as soon as a request shows up in IDLE.
    assign ready       = ((state_q == StIdle) && !mem_r_en && !mem_w_en) || (state_q == StDone);
    assign freeze      = ~ready;
    assign rd_data     = rd_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a behavioural async SRAM; covers the
// SRAM_MEM_CTRL_READ_CACHE_EN cases when that macro is defined.
module tb_sram_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [31:0] rd_data;
    logic        ready;
    logic        freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int total;
    int bad;
    int overlap;

    logic [15:0] sram_mem [0:63];
    logic [17:0] log_addr [0:31];
    logic [15:0] log_dq   [0:31];
    logic        log_we   [0:31];
    logic        log_oe   [0:31];
    logic [31:0] rdy_data;
    logic        rdy_frz;
    int          n;

    sram_mem_ctrl #(
        .WAIT_CYCLES(2),
        .ADDR_BASE  (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .alu_res    (alu_res),
        .val_rm     (val_rm),
        .rd_data    (rd_data),
        .ready      (ready),
        .freeze     (freeze),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[5:0]] <= sram_dq_out;
    end

    always @(negedge clk) begin
        if (!sram_we_n && !sram_dq_oe) overlap = overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one request, logs SRAM pins every non-ready cycle, releases after ready.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, output int cnt);
        @(posedge clk);
        #1;
        mem_w_en = w;
        mem_r_en = r;
        alu_res  = a;
        val_rm   = d;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            log_addr[cnt] = sram_addr;
            log_dq[cnt]   = sram_dq_out;
            log_we[cnt]   = sram_we_n;
            log_oe[cnt]   = sram_dq_oe;
            cnt = cnt + 1;
            if (cnt >= 32) begin
                check("ready_timeout", 32'(cnt), 32'd5);
                break;
            end
        end
        rdy_data = rd_data;
        rdy_frz  = freeze;
        @(posedge clk);
        #1;
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        overlap  = 0;
        rst      = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        alu_res  = '0;
        val_rm   = '0;
        for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);

        // Write 0xDEADBEEF to byte 1028 -> halfwords 2 and 3
        run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, n);
        check("wr_latency", 32'(n), 32'd5);
        for (int i = 1; i < 5; i++) begin
            check("wr_addr", 32'(log_addr[i]), (i < 3) ? 32'd2 : 32'd3);
            check("wr_dq", 32'(log_dq[i]), (i < 3) ? 32'hBEEF : 32'hDEAD);
            check("wr_we_n", 32'(log_we[i]), 32'd0);
            check("wr_oe", 32'(log_oe[i]), 32'd1);
        end
        check("wr_done_freeze", 32'(rdy_frz), 32'd0);
        check("wr_rd_data_kept", rdy_data, 32'h0);

        // Read back
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, n);
        check("rd_freeze_cycles", 32'(n), 32'd5);
        check("rd_data", rdy_data, 32'hDEADBEEF);
        check("rd_lo_addr", 32'(log_addr[1]), 32'd2);
        check("rd_hi_addr", 32'(log_addr[3]), 32'd3);
        check("rd_we_n", 32'(log_we[2]), 32'd1);
        check("rd_oe", 32'(log_oe[2]), 32'd0);

        // Simultaneous read+write: write wins
        run_access(1'b1, 1'b1, 32'd1024, 32'h12345678, n);
        check("sim_latency", 32'(n), 32'd5);
        check("sim_lo_addr", 32'(log_addr[1]), 32'd0);
        check("sim_hi_addr", 32'(log_addr[4]), 32'd1);
        check("sim_we_n", 32'(log_we[3]), 32'd0);
        check("sim_mem_lo", 32'(sram_mem[0]), 32'h5678);
        check("sim_mem_hi", 32'(sram_mem[1]), 32'h1234);
        check("sim_rd_data_kept", rdy_data, 32'hDEADBEEF);

        // Reset asserted in the middle of WR_HI
        @(posedge clk);
        #1;
        mem_w_en = 1'b1;
        alu_res  = 32'd1040;
        val_rm   = 32'h55556666;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_wr_hi_addr", 32'(sram_addr), 32'd9);
        check("mid_wr_hi_we_n", 32'(sram_we_n), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_we_n", 32'(sram_we_n), 32'd1);
        check("async_rst_oe", 32'(sram_dq_oe), 32'd0);
        check("async_rst_addr", 32'(sram_addr), 32'd0);
        check("async_rst_dq", 32'(sram_dq_out), 32'd0);
        check("async_rst_rd_data", rd_data, 32'h0);
        mem_w_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_freeze", 32'(freeze), 32'd0);

        // Back-to-back write then read at 1032
        run_access(1'b1, 1'b0, 32'd1032, 32'h0000AAAA, n);
        check("b2b_wr_latency", 32'(n), 32'd5);
        check("b2b_wr_addr", 32'(log_addr[1]), 32'd4);
        run_access(1'b0, 1'b1, 32'd1032, 32'h0, n);
        check("b2b_rd_latency", 32'(n), 32'd5);
        check("b2b_rd_hi_addr", 32'(log_addr[4]), 32'd5);
        check("b2b_rd_data", rdy_data, 32'h0000AAAA);

`ifdef SRAM_MEM_CTRL_READ_CACHE_EN
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, n);
        check("cache_miss_latency", 32'(n), 32'd5);
        check("cache_miss_data", rdy_data, 32'hDEADBEEF);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, n);
        check("cache_hit_latency", 32'(n), 32'd1);
        check("cache_hit_data", rdy_data, 32'hDEADBEEF);
        check("cache_hit_no_addr", 32'(sram_addr), 32'd3);
        run_access(1'b1, 1'b0, 32'd1028, 32'h00000001, n);
        check("cache_wr_latency", 32'(n), 32'd5);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, n);
        check("cache_upd_latency", 32'(n), 32'd1);
        check("cache_upd_data", rdy_data, 32'h00000001);
`endif

        check("no_we_without_oe", 32'(overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
